// File: rtl/writeback_stage_if.sv
// Bus bundle between the execute/LSU side and the writeback stage.
interface writeback_stage_if #(
  parameter int unsigned XLEN = 64
);
  // ALU result path (never back-pressured)
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_result;

  // Load response path
  logic            lsu_valid;
  logic            lsu_ready;
  logic [4:0]      lsu_rd;
  logic [2:0]      lsu_funct3;
  logic [2:0]      lsu_byte_off;
  logic [XLEN-1:0] lsu_rdata;

  // Register-file write port and status
  logic            rf_we;
  logic [4:0]      rf_addr;
  logic [XLEN-1:0] rf_data;
  logic            held_valid;
  logic [4:0]      held_rd;
  logic            ld_err;

  modport master (
    output alu_valid, alu_rd, alu_result,
    output lsu_valid, lsu_rd, lsu_funct3, lsu_byte_off, lsu_rdata,
    input  lsu_ready,
    input  rf_we, rf_addr, rf_data, held_valid, held_rd, ld_err
  );

  modport slave (
    input  alu_valid, alu_rd, alu_result,
    input  lsu_valid, lsu_rd, lsu_funct3, lsu_byte_off, lsu_rdata,
    output lsu_ready,
    output rf_we, rf_addr, rf_data, held_valid, held_rd, ld_err
  );
endinterface

// File: rtl/writeback_stage.sv
// Writeback stage: merges ALU results and extended load data onto the single
// register-file write port, with a 1-entry buffer for load/ALU collisions.
// Optional macro WB_RETIRE_CNT_EN adds per-source retired-write counters.
module writeback_stage #(
  parameter int unsigned XLEN = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  writeback_stage_if.slave  wb
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]       alu_wr_cnt,
  output logic [63:0]       ld_wr_cnt
`endif
);

  localparam int unsigned RD_W = 5;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_HELD  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [RD_W-1:0] held_rd_q, held_rd_d;
  logic [XLEN-1:0] held_data_q, held_data_d;
  logic            rf_we_q, rf_we_d;
  logic [RD_W-1:0] rf_addr_q, rf_addr_d;
  logic [XLEN-1:0] rf_data_q, rf_data_d;
  logic            ld_err_q, ld_err_d;
  logic            lsu_ready_q, lsu_ready_d;

  logic            ld_accept;
  logic            sel_alu;
  logic            sel_ld;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [31:0]     ld_word;
  logic [XLEN-1:0] ld_ext;
  logic            ld_bad_f3;

  // Lane selection and sign/zero extension of the incoming load
  always_comb begin
    ld_byte   = wb.lsu_rdata[{wb.lsu_byte_off, 3'b000} +: 8];
    ld_half   = wb.lsu_rdata[{wb.lsu_byte_off[2:1], 4'b0000} +: 16];
    ld_word   = wb.lsu_rdata[{wb.lsu_byte_off[2], 5'b00000} +: 32];
    ld_ext    = '0;
    ld_bad_f3 = 1'b0;
    case (wb.lsu_funct3)
      3'b000:  ld_ext = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b010:  ld_ext = {{(XLEN-32){ld_word[31]}}, ld_word};
      3'b011:  ld_ext = wb.lsu_rdata;
      3'b100:  ld_ext = XLEN'(ld_byte);
      3'b101:  ld_ext = XLEN'(ld_half);
      3'b110:  ld_ext = XLEN'(ld_word);
      default: ld_bad_f3 = 1'b1;
    endcase
  end

  // Next-state and write-port selection: ALU > held load > incoming load
  always_comb begin
    state_d     = state_q;
    held_rd_d   = held_rd_q;
    held_data_d = held_data_q;
    rf_addr_d   = rf_addr_q;
    rf_data_d   = rf_data_q;
    sel_alu     = 1'b0;
    sel_ld      = 1'b0;

    ld_accept   = wb.lsu_valid && lsu_ready_q;

    if (wb.alu_valid) begin
      sel_alu   = 1'b1;
      rf_addr_d = wb.alu_rd;
      rf_data_d = wb.alu_result;
      if (ld_accept) begin
        state_d     = ST_HELD;
        held_rd_d   = wb.lsu_rd;
        held_data_d = ld_ext;
      end
    end else if (state_q == ST_HELD) begin
      sel_ld    = 1'b1;
      rf_addr_d = held_rd_q;
      rf_data_d = held_data_q;
      state_d   = ST_EMPTY;
    end else if (ld_accept) begin
      sel_ld    = 1'b1;
      rf_addr_d = wb.lsu_rd;
      rf_data_d = ld_ext;
    end

    rf_we_d     = (sel_alu || sel_ld) && (rf_addr_d != '0);
    ld_err_d    = ld_accept && ld_bad_f3;
    lsu_ready_d = (state_d == ST_EMPTY);
  end

  // Stage state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      held_rd_q   <= '0;
      held_data_q <= '0;
      rf_we_q     <= 1'b0;
      rf_addr_q   <= '0;
      rf_data_q   <= '0;
      ld_err_q    <= 1'b0;
      lsu_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      held_rd_q   <= held_rd_d;
      held_data_q <= held_data_d;
      rf_we_q     <= rf_we_d;
      rf_addr_q   <= rf_addr_d;
      rf_data_q   <= rf_data_d;
      ld_err_q    <= ld_err_d;
      lsu_ready_q <= lsu_ready_d;
    end
  end

  assign wb.rf_we      = rf_we_q;
  assign wb.rf_addr    = rf_addr_q;
  assign wb.rf_data    = rf_data_q;
  assign wb.held_valid = (state_q == ST_HELD);
  assign wb.held_rd    = held_rd_q;
  assign wb.ld_err     = ld_err_q;
  assign wb.lsu_ready  = lsu_ready_q;

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] alu_wr_cnt_q, alu_wr_cnt_d;
  logic [63:0] ld_wr_cnt_q, ld_wr_cnt_d;

  // Count real register writes per source; rd=0 slots are not counted
  always_comb begin
    alu_wr_cnt_d = alu_wr_cnt_q + 64'(sel_alu && rf_we_d);
    ld_wr_cnt_d  = ld_wr_cnt_q + 64'(sel_ld && rf_we_d);
  end

  // Retired-write counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_wr_cnt_q <= '0;
      ld_wr_cnt_q  <= '0;
    end else begin
      alu_wr_cnt_q <= alu_wr_cnt_d;
      ld_wr_cnt_q  <= ld_wr_cnt_d;
    end
  end

  assign alu_wr_cnt = alu_wr_cnt_q;
  assign ld_wr_cnt  = ld_wr_cnt_q;
`endif

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage of the core. It merges ALU results and load responses into the single register-file write port (we/A3/D3).
- It sign- or zero-extends load data by funct3 and byte lane.
- A 1-entry holding buffer absorbs load/ALU collisions, so the in-order ALU path never stalls.
- All outputs are registered; the register file writes one cycle after selection.

Parameters:
- XLEN, 64, datapath width; must match riscky_pkg XLEN.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- alu_valid  input  1  ALU result present this cycle; never back-pressured.
- alu_rd  input  5  ALU destination register.
- alu_result  input  XLEN  ALU result.
- lsu_valid  input  1  load response valid.
- lsu_ready  output  1  stage can accept a load response.
- lsu_rd  input  5  load destination register.
- lsu_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU.
- lsu_byte_off  input  3  byte lane of the access within lsu_rdata.
- lsu_rdata  input  XLEN  raw 64-bit memory doubleword.
- rf_we  output  1  register-file write enable (to we).
- rf_addr  output  5  write address (to A3).
- rf_data  output  XLEN  write data (to D3).
- held_valid  output  1  holding buffer occupied; used by the hazard unit.
- held_rd  output  5  destination register of the held load.
- ld_err  output  1  one-cycle pulse, illegal funct3 accepted.

Behaviour:
- Reset (async, rst_n=0): rf_we=0, rf_addr=0, rf_data=0, held_valid=0, held_rd=0, ld_err=0, lsu_ready=0. Reset mid-operation drops the held load silently.
- After reset release, lsu_ready = !held_valid (registered state only; no combinational path from alu_valid).
- Load acceptance: a load is accepted when lsu_valid && lsu_ready. Extension happens at acceptance; the buffer stores the extended value.
- Extension:
  - The lane is selected by lsu_byte_off: LB/LBU use byte [off]; LH/LHU use halfword at off[2:1]; LW/LWU use word at off[2]; LD ignores off.
  - Signed types replicate the top bit to XLEN; unsigned types zero-fill.
  - Misalignment is the LSU's concern; low off bits are ignored for H/W/D.
  - funct3 111: data forced to 0, write still performed, ld_err pulses in the following cycle.
- Two-state holding buffer, EMPTY/HELD. Per-cycle selection priority: ALU > held load > incoming load.
  - EMPTY, alu_valid only: ALU written.
  - EMPTY, load only: load written.
  - EMPTY, both: ALU written; load goes to the buffer -> HELD.
  - HELD, alu_valid: ALU written; stay HELD; no load is accepted (ready=0).
  - HELD, no alu_valid: held load written -> EMPTY; ready returns to 1 the next cycle.
- Latency: a selected item appears on rf_we/rf_addr/rf_data exactly 1 cycle later. A collided load takes 2 or more cycles.
- rd=0: the item is consumed normally but rf_we=0 for that slot; rf_addr and rf_data still reflect the item.
- No item selected: rf_we=0 next cycle; rf_addr and rf_data hold their previous values.
- Same rd from ALU and held load: program-order ambiguity is resolved by the hazard unit via held_valid/held_rd. This stage simply writes ALU first, then the load.

Optional Feature:
- Macro WB_RETIRE_CNT_EN.
- Defined:
  - Adds outputs alu_wr_cnt[63:0] and ld_wr_cnt[63:0].
  - Each counter increments on every cycle its source drives rf_we=1; rd=0 writes are not counted.
  - Counters reset to 0 asynchronously and wrap modulo 2^64.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset then lone ALU: alu_valid=1, rd=5, result=0x1234 -> next cycle rf_we=1, rf_addr=5, rf_data=0x1234.
- LB sign extension: lsu_rdata=0x00000000_0000_80FF, off=1, funct3=000, rd=7 -> rf_data=0xFFFFFFFF_FFFFFF80.
  - Same data with LBU -> 0x80.
  - LWU with rdata=0x8000_0000_0000_0000, off=4 -> 0x0000_0000_8000_0000.
- Collision: ALU (rd=3, 0xA) and load (rd=4, LD 0xB) in cycle N.
  - N+1: write x3=0xA; held_valid=1, held_rd=4, lsu_ready=0.
  - N+1 with no ALU: N+2 writes x4=0xB; lsu_ready=1 again in N+2.
- HELD with ALU every cycle for 3 cycles -> the load stays held, lsu_ready stays 0; it drains the first cycle alu_valid=0.
- rd=0 ALU, then funct3=111 load to rd=9 -> first slot rf_we=0; second slot writes x9=0 and ld_err pulses once.
- rst_n asserted while HELD -> held_valid=0 and rf_we=0 immediately; after release lsu_ready=1 and no stale write occurs. With WB_RETIRE_CNT_EN defined, both counters read 0.
